lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive end of the LFSR serial signature link.
- Loads the same 4-bit seed as the generator and locally runs the identical LFSR for N_SHIFT cycles to form the expected signature.
- In parallel, deserializes the generator's serial stream (LSB first, qualified by Valid), compares it against the expected value, and reports done/match/err.
- Used as the self-check partner of the LFSR generator on the link and in system test.

Parameters:
- WIDTH, 4, LFSR and signature width in bits.
- N_SHIFT, 8, number of LFSR update cycles before the expected signature is final (1..31).
- TAPS, 4'b0111, feedback mask: fb = XOR of lfsr bits where TAPS=1 (default fb = L0^L1^L2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- seed  in  WIDTH  initial LFSR value, sampled on reset deassertion/start.
- start  in  1  synchronous restart pulse: reload seed, clear results.
- ser_in  in  1  serial data bit from generator OUT.
- ser_valid  in  1  ser_in qualifier (generator Valid).
- exp_sig  out  WIDTH  locally computed expected signature.
- rx_sig  out  WIDTH  deserialized received word.
- done  out  1  comparison complete, held.
- match  out  1  rx_sig==exp_sig, valid while done=1.
- err  out  1  rx_sig!=exp_sig, valid while done=1.

Behaviour:
- LFSR update: next = {fb, lfsr[WIDTH-1:1]}, where fb = ^(lfsr & TAPS).
- Reset (RST=0, async):
  - lfsr<=seed; shift_cnt<=0; bit_cnt<=0; rx_sig<=0.
  - done, match, err <=0.
  - state<=CALC. Leaving reset starts CALC immediately with no start pulse.
- The CALC and RECV sub-processes run concurrently; an FSM tracks them.
  - CALC: each cycle lfsr<=next and shift_cnt++. After N_SHIFT updates, lfsr freezes and calc_done=1. exp_sig = lfsr (visible at all times).
  - RECV: on each cycle with ser_valid=1 and bit_cnt<WIDTH: rx_sig[bit_cnt]<=ser_in (LSB first), bit_cnt++. When bit_cnt reaches WIDTH, rx_done=1.
  - ser_valid with bit_cnt==WIDTH: bit ignored, rx_sig unchanged.
  - Bits arriving during CALC are accepted; order of completion between CALC and RECV is irrelevant.
- FSM states: CALC -> WAIT -> DONE.
  - CALC -> WAIT when calc_done.
  - WAIT -> DONE on the first cycle both calc_done and rx_done hold (same cycle allowed; CALC may go straight to DONE).
- Entering DONE (one clock after both complete):
  - done<=1; match<=(rx_sig==exp_sig); err<=~match.
  - All three held until start or reset.
- start=1 in any state (including mid-CALC/RECV) takes effect the next edge:
  - Reload seed, clear counters, rx_sig, done, match, err; state<=CALC.
  - A ser_valid in the same cycle as start is discarded.
- ser_valid in DONE: ignored.
- Counters are sized to hold N_SHIFT and WIDTH respectively; no wrap.
- seed 0 is legal (LFSR locks at 0; expected signature 0).
- match and err are never both 1; both are 0 while done=0.

Test Plan:
- seed=4'b1000, generator-style stream bits 0,0,1,0 with ser_valid after reset -> exp_sig=4'b0100, rx_sig=4'b0100, done=1, match=1, err=0, holds for 20 cycles.
- seed=4'b1000, stream 1,0,1,0 -> rx_sig=4'b0101, done=1, match=0, err=1.
- seed=4'b0001, all 4 bits sent in cycles 0-3 (during CALC) -> done asserts only after the N_SHIFT-th update +1 cycle; exp_sig=4'b1000, stream 0,0,0,1 gives match=1.
- seed=0, stream 0,0,0,0 with gaps (ser_valid low between bits) -> exp_sig=0, match=1; 6 extra valid bits after the 4th leave rx_sig unchanged.
- start pulse after 2 received bits, then seed=4'b1000 and full stream 0,0,1,0 -> prior bits discarded, done=0 until the new completion, then match=1.
- RST low mid-RECV and in DONE -> done/match/err/rx_sig=0 immediately (async), CALC restarts from seed on release.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive end of the LFSR serial signature link.
// Runs a local copy of the generator's LFSR to form the expected signature
// while deserializing the incoming stream (LSB first), then reports a
// held done/match/err verdict once both sides are complete.
module lfsr_checker #(
    parameter int               WIDTH   = 4,
    parameter int               N_SHIFT = 8,
    parameter logic [WIDTH-1:0] TAPS    = 4'b0111
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] exp_sig,
    output logic [WIDTH-1:0] rx_sig,
    output logic             done,
    output logic             match,
    output logic             err
);

    localparam int SCW = $clog2(N_SHIFT + 1);
    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [SCW-1:0] SC_MAX = SCW'(N_SHIFT);
    localparam logic [BCW-1:0] BC_MAX = BCW'(WIDTH);

    localparam logic [1:0] CALC = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [SCW-1:0]   shift_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] rx_next;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             calc_done;
    logic             rx_done;
    logic             rx_take;
    logic             sig_eq;

    assign calc_done = (shift_cnt == SC_MAX);
    assign rx_done   = (bit_cnt == BC_MAX);
    assign lfsr_next = {^(lfsr & TAPS), lfsr[WIDTH-1:1]};
    assign exp_sig   = lfsr;
    assign sig_eq    = (rx_sig == exp_sig);
    // a bit arriving alongside start belongs to the aborted transfer
    assign rx_take   = ser_valid && !rx_done && (state != DONE) && !start;

    // Drop the incoming bit into the slot selected by bit_cnt
    always_comb begin
        rx_next = rx_sig;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt == BCW'(i)) rx_next[i] = ser_in;
        end
    end

    // Next FSM state; CALC may jump straight to DONE if RECV already finished
    always_comb begin
        state_next = state;
        case (state)
            CALC: begin
                if (calc_done && rx_done) state_next = DONE;
                else if (calc_done)       state_next = WAIT;
            end
            WAIT:    if (calc_done && rx_done) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = CALC;
        endcase
    end

    // Local LFSR: step N_SHIFT times from seed, then freeze
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lfsr      <= seed;
            shift_cnt <= '0;
        end else if (start) begin
            lfsr      <= seed;
            shift_cnt <= '0;
        end else if (!calc_done) begin
            lfsr      <= lfsr_next;
            shift_cnt <= shift_cnt + 1'b1;
        end
    end

    // Deserializer: accept WIDTH qualified bits, ignore any extras
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_sig  <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            rx_sig  <= '0;
            bit_cnt <= '0;
        end else if (rx_take) begin
            rx_sig  <= rx_next;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // FSM and verdict, latched on the transition into DONE and held
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= CALC;
            done  <= 1'b0;
            match <= 1'b0;
            err   <= 1'b0;
        end else if (start) begin
            state <= CALC;
            done  <= 1'b0;
            match <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            if (state != DONE && state_next == DONE) begin
                done  <= 1'b1;
                match <= sig_eq;
                err   <= !sig_eq;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: randomized bench for lfsr_checker with a cycle-level
// reference model of the expected signature, received word and verdict timing.
module tb_lfsr_checker;

    localparam int WIDTH   = 4;
    localparam int N_SHIFT = 8;
    localparam int TAPS    = 'b0111;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [WIDTH-1:0] seed = '0;
    logic             start = 1'b0;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic [WIDTH-1:0] exp_sig;
    logic [WIDTH-1:0] rx_sig;
    logic             done;
    logic             match;
    logic             err;

    lfsr_checker #(.WIDTH(WIDTH), .N_SHIFT(N_SHIFT), .TAPS(4'b0111)) dut (
        .CLK(CLK), .RST(RST), .seed(seed), .start(start),
        .ser_in(ser_in), .ser_valid(ser_valid),
        .exp_sig(exp_sig), .rx_sig(rx_sig),
        .done(done), .match(match), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: edges since (re)start, accepted bits, word
    int k, nacc, rx_m, recv_edge, sd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // signature after n updates: shift right, new MSB = parity of tapped bits
    function automatic int sig_after(input int s, input int n);
        int l, par;
        l = s;
        for (int i = 0; i < n; i++) begin
            par = 0;
            for (int b = 0; b < WIDTH; b++) par += ((l & TAPS) >> b) & 1;
            l = (l >> 1) | ((par % 2) << (WIDTH - 1));
        end
        return l;
    endfunction

    function automatic int done_edge();
        return (recv_edge > N_SHIFT ? recv_edge : N_SHIFT) + 1;
    endfunction

    task automatic restart_model(input int s);
        k = 0; nacc = 0; rx_m = 0; recv_edge = -1; sd = s;
    endtask

    task automatic check_outputs();
        bit d;
        int sig;
        sig = sig_after(sd, N_SHIFT);
        d = (recv_edge >= 0) && (k >= done_edge());
        chk("exp_sig", 32'(exp_sig), 32'(sig_after(sd, k < N_SHIFT ? k : N_SHIFT)));
        chk("rx_sig",  32'(rx_sig),  32'(rx_m));
        chk("done",    32'(done),    32'(d));
        chk("match",   32'(match),   32'(d && rx_m == sig));
        chk("err",     32'(err),     32'(d && rx_m != sig));
    endtask

    // one clock with the given serial input, then check
    task automatic step(input bit v, input bit b);
        ser_valid = v; ser_in = b; start = 1'b0;
        if (v && nacc < WIDTH) begin
            rx_m = rx_m | (int'(b) << nacc);
            nacc++;
            if (nacc == WIDTH) recv_edge = k + 1;
        end
        @(posedge CLK); #1;
        k++;
        check_outputs();
    endtask

    // start pulse with a valid bit alongside that must be dropped
    task automatic do_start(input int s);
        seed = WIDTH'(s); start = 1'b1; ser_valid = 1'b1; ser_in = 1'($urandom);
        @(posedge CLK); #1;
        start = 1'b0; ser_valid = 1'b0;
        restart_model(s);
        check_outputs();
    endtask

    task automatic do_reset(input int s);
        ser_valid = 1'b0; start = 1'b0; seed = WIDTH'(s);
        RST = 1'b0;
        #1;
        chk("rst_rx_sig", 32'(rx_sig), 0);
        chk("rst_done",   32'(done),   0);
        chk("rst_match",  32'(match),  0);
        chk("rst_err",    32'(err),    0);
        chk("rst_exp",    32'(exp_sig), 32'(s));
        @(negedge CLK);
        RST = 1'b1;
        restart_model(s);
    endtask

    // drive a stream (correct signature or corrupted), optional gaps,
    // optional restart after two accepted bits; keep going past done
    task automatic run_case(input bit want_match, input bit gaps, input bit rs2);
        int word;
        bit v;
        word = sig_after(sd, N_SHIFT);
        if (!want_match) word = word ^ (1 + int'($urandom_range(0, 14)));
        for (int c = 0; c < 44; c++) begin
            if (rs2 && nacc == 2) begin
                do_start(sd);
                rs2 = 1'b0;
            end
            if (nacc < WIDTH) v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            else              v = 1'($urandom);
            step(v, nacc < WIDTH ? 1'((word >> nacc) & 1) : 1'($urandom));
        end
    endtask

    initial begin
        #2;
        do_reset(4'b1000);
        run_case(1'b1, 1'b0, 1'b0);
        do_start(4'b1000);
        run_case(1'b0, 1'b0, 1'b0);
        do_start(4'b0001);
        run_case(1'b1, 1'b0, 1'b0);
        do_start(0);
        run_case(1'b1, 1'b1, 1'b0);
        do_start(4'b1000);
        run_case(1'b1, 1'b0, 1'b1);
        // reset in the middle of reception
        do_start(int'($urandom_range(0, 15)));
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        do_reset(int'($urandom_range(0, 15)));
        run_case(1'b1, 1'b1, 1'b0);
        // reset while in DONE
        do_reset(int'($urandom_range(0, 15)));
        run_case(1'($urandom), 1'b1, 1'b0);
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0) do_reset(int'($urandom_range(0, 15)));
            else                           do_start(int'($urandom_range(0, 15)));
            run_case(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
